tdec_wrap_crc24_attach: RTL and testbench
=========================================

TDEC_WRAP_CRC24_ATTACH -- requirements
Module: tdec_wrap_crc24_attach

Interface
REQ-001 Parameter: CRC_INIT, default 24'h000000, CRC register value at the start of each block.
REQ-002 clk  input  1  single block clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_vld  input  1  payload byte valid.
REQ-005 in_rdy  output  1  block accepts payload byte this cycle.
REQ-006 in_dat  input  8  payload byte; bit 7 is first in transmission order.
REQ-007 in_last  input  1  qualifies in_dat as final payload byte of the block.
REQ-008 out_vld  output  1  output byte valid.
REQ-009 out_rdy  input  1  downstream accepts output byte this cycle.
REQ-010 out_dat  output  8  payload byte or appended CRC byte.
REQ-011 out_last  output  1  marks final byte of block (CRC byte 2).
REQ-012 out_crc  output  1  marks out_dat as an appended CRC byte.

Function
REQ-013 Polynomial SHALL be CRC-24B: g(D)=D^24+D^23+D^6+D^5+D+1 (0x800063), no reflection, no final XOR.
REQ-014 CRC update SHALL be 8-bit parallel, one byte per accepted transfer, in_dat[7] processed first.
REQ-015 Input transfer occurs when in_vld and in_rdy are both high; output transfer when out_vld and out_rdy are both high.
REQ-016 Output stage SHALL be one register (out_vld/out_dat/out_last/out_crc); register free = !out_vld or out_rdy.
REQ-017 States: IDLE, DATA, CRC0, CRC1, CRC2.
REQ-018 in_rdy = (state IDLE or DATA) and output register free; combinational, no dependence on in_vld.
REQ-019 IDLE: CRC register holds CRC_INIT; first accepted byte -> DATA (or CRC0 if in_last).
REQ-020 DATA: each accepted byte loads output register (out_crc=0, out_last=0) and updates CRC; accepted byte with in_last -> CRC0.
REQ-021 Payload latency: byte accepted in cycle N appears on out_dat in cycle N+1.
REQ-022 CRC0/CRC1/CRC2: when output register free, load crc[23:16], crc[15:8], crc[7:0] respectively, out_crc=1; out_last=1 only for crc[7:0].
REQ-023 CRC0 is entered with the CRC already including the last byte; first CRC byte loads in the cycle after the last payload accept if the register is free.
REQ-024 On loading crc[7:0] (leaving CRC2): state -> IDLE, CRC register reloads CRC_INIT; new block accepted no earlier than the following cycle.
REQ-025 Backpressure: while out_vld=1 and out_rdy=0, out_dat/out_last/out_crc SHALL hold stable; no state or CRC change.
REQ-026 Single-byte block (first byte with in_last) SHALL produce exactly 4 output bytes.
REQ-027 Zero-length blocks not supported; every block carries at least one payload byte.
REQ-028 Full-rate: with out_rdy held high, one byte per cycle sustained; per block of L bytes, in_rdy low for exactly 3 cycles (CRC0..CRC2).
REQ-029 in_vld without in_rdy SHALL have no effect; in_dat/in_last ignored.

Reset
REQ-030 rst high SHALL asynchronously force: state IDLE, CRC register CRC_INIT, out_vld 0, out_dat 8'h00, out_last 0, out_crc 0.
REQ-031 in_rdy SHALL be 1 while rst is high (output register empty) but no transfer is recorded.
REQ-032 Reset mid-block SHALL discard the partial block and any pending CRC bytes; next accepted byte starts a new block.

Verification
REQ-033 Single byte 0x01, in_last=1, out_rdy=1 -> out_dat 01, 80, 00, 63 on 4 consecutive cycles; out_crc 0,1,1,1; out_last only on 63.
REQ-034 Single byte 0x00, in_last=1 -> out 00, 00, 00, 00; in_rdy low exactly 3 cycles.
REQ-035 Random block (1..6144 bytes) vs reference model; re-running CRC-24B over payload+3 CRC bytes -> remainder 24'h000000.
REQ-036 out_rdy toggled randomly during payload and CRC phases -> no dropped/duplicated bytes, out_dat stable while stalled, CRC unchanged.
REQ-037 rst asserted during CRC1 of a block -> out_vld 0 immediately; next block 0x01/last -> 01, 80, 00, 63 (no residue).
REQ-038 Back-to-back blocks with in_vld held high -> second block's first byte accepted the cycle after crc[7:0] loads; both CRCs correct.

Source files
------------

// File: rtl/tdec_wrap_crc24_attach.sv
// tdec_wrap_crc24_attach: passes payload bytes through and appends a CRC-24B (0x800063, MSB first) as three trailing bytes
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_vld/in_rdy/in_dat/in_last   payload byte stream, in_dat[7] first on the line
//   out_vld/out_rdy/out_dat        output byte stream through a single register
//   out_last                       final byte of the block (third CRC byte)
//   out_crc                        out_dat carries a CRC byte
module tdec_wrap_crc24_attach #(
    parameter logic [23:0] CRC_INIT = 24'h000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    output logic       in_rdy,
    input  logic [7:0] in_dat,
    input  logic       in_last,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic [7:0] out_dat,
    output logic       out_last,
    output logic       out_crc
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] DATA = 3'd1;
    localparam logic [2:0] CRC0 = 3'd2;
    localparam logic [2:0] CRC1 = 3'd3;
    localparam logic [2:0] CRC2 = 3'd4;
    logic [2:0]  state;
    logic [23:0] crc;
    logic [23:0] crc_nxt;
    logic        free;
    logic        in_fire;
    logic        crc_load;
    assign free     = !out_vld || out_rdy;
    assign in_rdy   = (state == IDLE || state == DATA) && free;
    assign in_fire  = in_vld && in_rdy;
    assign crc_load = (state == CRC0 || state == CRC1 || state == CRC2) && free;
    // eight serial LFSR steps unrolled into one combinational update, bit 7 first
    always_comb begin
        crc_nxt = crc;
        for (int i = 7; i >= 0; i--)
            crc_nxt = {crc_nxt[22:0], 1'b0} ^ ((crc_nxt[23] ^ in_dat[i]) ? 24'h800063 : 24'h000000);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            crc      <= CRC_INIT;
            out_vld  <= 1'b0;
            out_dat  <= 8'h00;
            out_last <= 1'b0;
            out_crc  <= 1'b0;
        end else if (in_fire) begin
            out_vld  <= 1'b1;
            out_dat  <= in_dat;
            out_last <= 1'b0;
            out_crc  <= 1'b0;
            crc      <= crc_nxt;
            state    <= in_last ? CRC0 : DATA;
        end else if (crc_load) begin
            out_vld  <= 1'b1;
            out_crc  <= 1'b1;
            out_dat  <= state == CRC0 ? crc[23:16] : state == CRC1 ? crc[15:8] : crc[7:0];
            out_last <= state == CRC2;
            state    <= state == CRC0 ? CRC1 : state == CRC1 ? CRC2 : IDLE;
            crc      <= state == CRC2 ? CRC_INIT : crc;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tdec_wrap_crc24_attach.sv
// tb_tdec_wrap_crc24_attach: randomized self-checking bench against a polynomial long-division CRC model
module tb_tdec_wrap_crc24_attach;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [7:0] in_dat = 8'h00;
    logic       in_last = 1'b0;
    logic       out_vld;
    logic       out_rdy = 1'b1;
    logic [7:0] out_dat;
    logic       out_last;
    logic       out_crc;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_bad = 0;
    bit rdy_rand = 1'b0;
    bit stall = 1'b0;
    logic [9:0] held;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] pay[$];
    int got_base = 0;

    tdec_wrap_crc24_attach dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .out_last(out_last), .out_crc(out_crc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always begin
        @(posedge clk);
        #1 out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // records output transfers and flags any change of a stalled output byte
    always @(negedge clk) begin
        if (rst) stall = 1'b0;
        else begin
            if (stall && {out_vld, out_crc, out_last, out_dat} !== {1'b1, held}) stall_bad++;
            if (out_vld && out_rdy) got_q.push_back({out_crc, out_last, out_dat});
            stall = out_vld && !out_rdy;
            held = {out_crc, out_last, out_dat};
        end
    end

    // remainder of M(x)*x^24 divided by g(x), done as plain binary long division
    function automatic logic [23:0] ref_crc(input logic [7:0] m[$]);
        bit b[$];
        logic [24:0] g = 25'h1800063;
        logic [23:0] r = '0;
        foreach (m[k]) for (int j = 7; j >= 0; j--) b.push_back(m[k][j]);
        for (int j = 0; j < 24; j++) b.push_back(1'b0);
        for (int i = 0; i < b.size() - 24; i++)
            if (b[i]) for (int j = 0; j < 25; j++) b[i + j] ^= g[24 - j];
        for (int i = b.size() - 24; i < b.size(); i++) r = {r[22:0], b[i]};
        return r;
    endfunction

    task automatic expect_block();
        logic [23:0] r = ref_crc(pay);
        foreach (pay[k]) exp_q.push_back({2'b00, pay[k]});
        exp_q.push_back({2'b10, r[23:16]});
        exp_q.push_back({2'b10, r[15:8]});
        exp_q.push_back({2'b11, r[7:0]});
    endtask

    task automatic fill(input int n);
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
    endtask

    task automatic drive_block(input bit gaps, output int fe, output int le);
        int i = 0;
        fe = -1;
        le = -1;
        while (i < pay.size()) begin
            @(posedge clk);
            #2;
            if (gaps && ($urandom_range(0, 3) == 0 || !in_rdy)) begin
                in_vld = 1'($urandom_range(0, 1)) & !in_rdy;
                in_dat = 8'($urandom);
                in_last = 1'($urandom);
            end else begin
                in_vld = 1'b1;
                in_dat = pay[i];
                in_last = (i == pay.size() - 1);
                if (in_rdy) begin
                    if (i == 0) fe = cyc + 1;
                    le = cyc + 1;
                    i++;
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #2 in_vld = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_stream(input string nm);
        int n = 0;
        int bad = 0;
        int sb = stall_bad;
        logic [7:0] blk[$];
        while (got_q.size() - got_base < exp_q.size() && n < 40000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        checks++;
        if (got_q.size() - got_base !== exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d bytes, expected %0d", nm, got_q.size() - got_base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (got_base + i >= got_q.size() || got_q[got_base + i] !== exp_q[i]) begin
                errors++;
                if (bad++ < 8) $display("FAIL %s byte %0d: got %h, expected %h", nm, i,
                    (got_base + i < got_q.size()) ? got_q[got_base + i] : 10'h3ff, exp_q[i]);
            end
        end
        for (int i = got_base; i < got_q.size(); i++) begin
            blk.push_back(got_q[i][7:0]);
            if (got_q[i][8]) begin
                checks++;
                if (ref_crc(blk) !== 24'h000000) begin
                    errors++;
                    $display("FAIL %s residue: got %h, expected 000000", nm, ref_crc(blk));
                end
                blk.delete();
            end
        end
        checks++;
        if (stall_bad !== sb) begin
            errors++;
            $display("FAIL %s stall_hold: %0d unstable stalled cycles, expected 0", nm, stall_bad - sb);
        end
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #3 in_vld = 1'b1;
        in_dat = 8'hA5;
        in_last = 1'b1;
        #20;
        checks++;
        if ({out_vld, out_dat, out_last, out_crc, in_rdy} !== 12'b0_00000000_0_0_1) begin
            errors++;
            $display("FAIL reset_outputs: got vld=%b dat=%h last=%b crc=%b rdy=%b, expected 0 00 0 0 1",
                out_vld, out_dat, out_last, out_crc, in_rdy);
        end
        in_vld = 1'b0;
        in_last = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_transfer: got out_vld=%b, expected 0", out_vld);
        end
        got_base = got_q.size();
    endtask

    task automatic test_single(input logic [7:0] b, input logic [23:0] c);
        logic [7:0] ed[4];
        ed[0] = b;
        ed[1] = c[23:16];
        ed[2] = c[15:8];
        ed[3] = c[7:0];
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_%h_rdy: got in_rdy=%b, expected 1", b, in_rdy);
        end
        in_vld = 1'b1;
        in_dat = b;
        in_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2 in_vld = 1'b0;
            in_last = 1'b0;
            checks++;
            if ({out_vld, out_dat, out_crc, out_last, in_rdy} !== {1'b1, ed[k], k > 0, k == 3, k == 3}) begin
                errors++;
                $display("FAIL single_%h_cycle%0d: got vld=%b dat=%h crc=%b last=%b rdy=%b, expected 1 %h %b %b %b",
                    b, k, out_vld, out_dat, out_crc, out_last, in_rdy, ed[k], k > 0, k == 3, k == 3);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_%h_end: got out_vld=%b, expected 0", b, out_vld);
        end
        got_base = got_q.size();
    endtask

    task automatic test_random();
        int fe, le;
        int lens[7] = '{1, 2, 6144, 0, 0, 0, 0};
        rdy_rand = 1'b1;
        for (int k = 3; k < 7; k++) lens[k] = $urandom_range(1, 300);
        foreach (lens[k]) begin
            fill(lens[k]);
            expect_block();
            drive_block(1'b1, fe, le);
            idle();
        end
        check_stream("random");
        rdy_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        int fe, le;
        int n = 0;
        rdy_rand = 1'b0;
        fill(10);
        drive_block(1'b0, fe, le);
        idle();
        while (!(out_vld && out_crc && !out_last) && n < 100) begin
            @(posedge clk);
            #2 n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_vld, out_crc, out_last, out_dat, in_rdy} !== 12'b0_0_0_00000000_1 || n >= 100) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b crc=%b last=%b dat=%h rdy=%b waited=%0d, expected 0 0 0 00 1",
                out_vld, out_crc, out_last, out_dat, in_rdy, n);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        got_base = got_q.size();
        exp_q.delete();
        pay.delete();
        pay.push_back(8'h01);
        expect_block();
        drive_block(1'b0, fe, le);
        idle();
        check_stream("after_reset");
    endtask

    task automatic test_back_to_back();
        int fe1, le1, fe2, le2;
        rdy_rand = 1'b0;
        fill($urandom_range(1, 20));
        expect_block();
        drive_block(1'b0, fe1, le1);
        fill($urandom_range(1, 20));
        expect_block();
        drive_block(1'b0, fe2, le2);
        idle();
        checks++;
        if (fe2 - le1 !== 4) begin
            errors++;
            $display("FAIL b2b_gap: got %0d edges between blocks, expected 4", fe2 - le1);
        end
        check_stream("b2b");
    endtask

    initial begin
        test_reset();
        test_single(8'h01, 24'h800063);
        test_single(8'h00, 24'h000000);
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
